x_top_uart_rx: RTL

UART receiver that deserialises the line driven by the team's UART transmitter into bytes. Frame format: one start bit, 8 data bits LSB first, one even-parity bit, then stop/idle high. It oversamples the asynchronous `i_rx` line with the system clock, checks parity and the stop bit, and presents each byte through a one-entry valid/accept holding register to the downstream consumer (register file or RX FIFO).

---
 rtl/x_top_uart_rx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/x_top_uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, with a
// one-entry valid/accept holding register in front of the consumer.
module x_top_uart_rx #(
    parameter int p_clk_hz = 1000000,
    parameter int p_baud   = 9600
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_accept,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_overrun
);
    localparam int BIT  = p_clk_hz / p_baud;
    localparam int HALF = BIT / 2;
    localparam int TW   = (BIT > 2) ? $clog2(BIT) : 1;

    generate
        if (BIT < 4) begin : g_bit_check
            $error("x_top_uart_rx: p_clk_hz/p_baud must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q   <= 2'b11;
            state_q  <= S_IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], i_rx};
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TW'(1);
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        data_d   = data_q;
        valid_d  = valid_q;
        perr_d   = perr_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;

        if (valid_q && i_accept) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (timer_q == TW'(HALF - 1)) begin
                    timer_d  = '0;
                    bitcnt_d = '0;
                    state_d  = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (timer_q == TW'(BIT - 1)) begin
                    timer_d  = '0;
                    shift_d  = {rx_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (timer_q == TW'(BIT - 1)) begin
                    timer_d = '0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (timer_q == TW'(BIT - 1)) begin
                    timer_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                        // A same-cycle accept frees the slot for the new byte.
                        if (!valid_q || i_accept) begin
                            data_d  = shift_q;
                            perr_d  = (^shift_q) ^ par_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                timer_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_overrun    = ovr_q;
endmodule
